elastic_buffer_flushable: RTL

//  Parametrised successor of the two-entry flushable spill register: a Depth-entry valid/ready

---
 rtl/axi_buf_pkg.sv | 18 +
 rtl/elastic_buffer_ptr.sv | 27 ++
 rtl/elastic_buffer_flushable.sv | 124 ++++++++++++
 3 files changed

// File: rtl/axi_buf_pkg.sv
// Shared sizing helpers and configuration type for the AXI channel buffers.
package axi_buf_pkg;

  typedef struct packed {
    int unsigned DataWidth;
    int unsigned Depth;
  } buf_cfg_t;

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // A single-entry pointer still needs one bit to stay a legal vector.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/elastic_buffer_ptr.sv
// Wrapping read/write pointer for the elastic buffer; wraps at Depth-1 for any Depth.
module elastic_buffer_ptr
  import axi_buf_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        clr_i,
  input  logic                        inc_i,
  output logic [ptr_width(Depth)-1:0] ptr_o
);

  localparam int unsigned     PW   = ptr_width(Depth);
  localparam logic [PW-1:0]   Last = PW'(Depth - 1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_o <= '0;
    end else if (clr_i) begin
      ptr_o <= '0;
    end else if (inc_i) begin
      ptr_o <= (ptr_o == Last) ? '0 : ptr_o + PW'(1);
    end
  end

endmodule

// File: rtl/elastic_buffer_flushable.sv
// Depth-entry valid/ready elastic buffer with flush and occupancy output.
// Optional macro ELASTIC_BUFFER_WATERMARK_EN adds the max_count_o high-water mark.
module elastic_buffer_flushable
  import axi_buf_pkg::*;
#(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Depth     = 2,
  parameter bit          Bypass    = 1'b0
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        flush_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  input  logic [DataWidth-1:0]        data_i,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic [DataWidth-1:0]        data_o,
  output logic [cnt_width(Depth)-1:0] count_o
`ifdef ELASTIC_BUFFER_WATERMARK_EN
  ,
  output logic [cnt_width(Depth)-1:0] max_count_o
`endif
);

  if (Bypass) begin : g_bypass
    assign valid_o = valid_i;
    assign ready_o = ready_i;
    assign data_o  = data_i;
    assign count_o = '0;
`ifdef ELASTIC_BUFFER_WATERMARK_EN
    assign max_count_o = '0;
`endif
  end else begin : g_buf
    localparam int unsigned   CW   = cnt_width(Depth);
    localparam int unsigned   PW   = ptr_width(Depth);
    localparam logic [CW-1:0] Full = CW'(Depth);

    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [CW-1:0]        count;
    logic [DataWidth-1:0] mem [Depth];
    logic                 push;
    logic                 pop;

    // ready_o ignores ready_i so no path runs from downstream back to upstream.
    assign ready_o = (count != Full) & ~flush_i;
    assign valid_o = (count != '0);
    assign data_o  = mem[rd_ptr];
    assign count_o = count;
    assign push    = valid_i & ready_o;
    assign pop     = valid_o & ready_i;

    elastic_buffer_ptr #(
      .Depth(Depth)
    ) u_wr_ptr (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .clr_i(flush_i),
      .inc_i(push),
      .ptr_o(wr_ptr)
    );

    elastic_buffer_ptr #(
      .Depth(Depth)
    ) u_rd_ptr (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .clr_i(flush_i),
      .inc_i(pop),
      .ptr_o(rd_ptr)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        count <= '0;
      end else if (flush_i) begin
        count <= '0;
      end else begin
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        for (int unsigned i = 0; i < Depth; i++) begin
          mem[i] <= '0;
        end
      end else if (push) begin
        mem[wr_ptr] <= data_i;
      end
    end

`ifdef ELASTIC_BUFFER_WATERMARK_EN
    logic [CW-1:0] max_count;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        max_count <= '0;
      end else if (flush_i) begin
        max_count <= '0;
      end else if (count > max_count) begin
        max_count <= count;
      end
    end

    assign max_count_o = max_count;
`endif

    a_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i)
      !(push && (count == Full)));

    a_no_underflow : assert property (@(posedge clk_i) disable iff (rst_i)
      !(pop && (count == '0)));

    a_upstream_hold : assert property (@(posedge clk_i) disable iff (rst_i)
      (valid_i && !ready_o) |=> (valid_i && $stable(data_i)));
  end

endmodule
